idex_reg: RTL and testbench
===========================

# idex_reg

Decode-to-execute pipeline register with operand capture and hazard interlock. It takes the decoded instruction, the register-file read data and the forwarding results from the operand forwarding mux. It latches the resolved source operands for the execute stage. It stalls decode on hazards the forwarding path cannot cover, inserting bubbles, and honours execute-stage backpressure and branch flush.

## Interface
Parameters:
- none (widths come from `common`/`pipes`)

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  idex_reg accepts the decode instruction this cycle
- dataD  in  decode_data_t  decoded instruction (ra1, ra2, dst, ctl)
- rd1, rd2  in  word_t  register-file read data for ra1/ra2
- fwd_srca, fwd_srcb  in  fwd_data_t  forwarding results (enable, data)
- ex_memread  in  1  instruction in E is a load
- ex_dst  in  creg_addr_t  destination of instruction in E
- mem_regwrite  in  1  instruction in M writes a register
- mem_dst  in  creg_addr_t  destination of instruction in M
- flush  in  1  redirect from E; kill register contents
- exe_ready  in  1  execute stage accepts out_* this cycle
- out_valid  out  1  out_data is a valid instruction
- out_data  out  idex_data_t  registered instruction plus resolved srca/srcb
- perf_bubble_cnt, perf_hold_cnt  out  32 each  performance counters (see Configuration)

## Operation
- Operand resolution:
  - srca = fwd_srca.enable ? fwd_srca.data : rd1.
  - srcb = fwd_srcb.enable ? fwd_srcb.data : rd2.
- Hazard (combinational), true when any source register (ra1 or ra2) that the instruction uses is non-zero and either:
  - (ex_memread && ex_dst == src), or
  - (mem_regwrite && mem_dst == src).
- Covered producers: E-stage ALU results and W-stage results are forwarded; M-stage producers and loads in E are not, hence the stall.
- Advance condition: advance = exe_ready || !out_valid.
- in_ready = advance && !hazard && !flush.
- Register update on a clock edge, in priority order:
  1. flush: out_valid←0; contents don't-care, held.
  2. else if advance && in_valid && !hazard: capture dataD, srca, srcb; out_valid←1.
  3. else if advance: out_valid←0 (bubble).
  4. else (out_valid && !exe_ready): hold all contents unchanged.
- State machine on out_valid:
  - EMPTY→FULL on capture.
  - FULL→FULL on capture or hold.
  - FULL→EMPTY on flush, or on advance with no capture.
  - EMPTY→EMPTY otherwise.
- Captured operands stay frozen during hold. Forwarding is applied only at capture.

## Timing
- Reset (resetn=0, asynchronous): out_valid=0, out_data all-zero, counters 0. in_ready follows its combinational equation after reset.
- Latency: one cycle, from the capture edge to out_data/out_valid.
- in_ready depends combinationally on exe_ready, hazard and flush. There is no combinational path from inputs to out_*.
- Load-use: a load in E with a matching dst inserts one bubble. The load then sits in M, so the hazard persists one more cycle. Total 2 bubbles before the consumer is captured with W-stage forwarding.
- Simultaneous flush and hazard: flush wins; no capture, out_valid=0.
- Simultaneous flush and hold: flush wins; out_valid=0.
- Reset asserted mid-hold: contents are discarded immediately.

## Configuration
- IDEX_PERF_EN defined: perf_bubble_cnt increments on each edge taking rule 3 while in_valid && hazard. perf_hold_cnt increments on each edge taking rule 4. Both counters wrap modulo 2^32 and are cleared by reset.
- IDEX_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `pipes` gains `idex_data_t` = {decode_data_t instr; word_t srca; word_t srcb}.
- Sub-module `hazard_detect`: combinational; takes ra1/ra2 use flags, ex/mem dst info; outputs hazard.
- Register and perf logic live in idex_reg.

## Test plan
- Forwarding select: rd1=0x11, fwd_srca={1,0xAA}, rd2=0x22, fwd_srcb={0,x}, exe_ready=1, in_valid=1 → next cycle out_valid=1, srca=0xAA, srcb=0x22.
- Load-use: ex_memread=1, ex_dst=5, dataD.ra1=5 → in_ready=0 and two bubbles (out_valid=0), then capture with W-forwarded data; perf_bubble_cnt=2.
- x0 immunity: ex_memread=1, ex_dst=0, ra1=0 → no stall, in_ready=1.
- Backpressure: FULL with srca=0x1234, exe_ready=0 for 3 cycles while rd1/fwd change → out_data unchanged, in_ready=0, perf_hold_cnt=3.
- Flush priority: flush=1 together with hazard and exe_ready=0 → next cycle out_valid=0, in_ready=0 during the flush cycle.
- Async reset: drop resetn mid-hold, between clock edges → out_valid=0 and out_data=0 immediately, counters 0.

Source files
------------

// File: rtl/idex_reg_pkg.sv
// Shared types for the decode-to-execute pipeline register: word and register
// address widths, decoded instruction, forwarding bundle and the registered
// ID/EX payload. Also holds the operand-select helper used at capture.
package idex_reg_pkg;

  localparam int XLEN   = 32;
  localparam int CREG_W = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [CREG_W-1:0] creg_addr_t;

  // Control bits carried with the instruction; use_ra* say which sources
  // the instruction actually reads.
  typedef struct packed {
    logic       use_ra1;
    logic       use_ra2;
    logic       regwrite;
    logic       memread;
    logic [3:0] alu_op;
  } ctl_t;

  typedef struct packed {
    creg_addr_t ra1;
    creg_addr_t ra2;
    creg_addr_t dst;
    ctl_t       ctl;
  } decode_data_t;

  typedef struct packed {
    logic  enable;
    word_t data;
  } fwd_data_t;

  typedef struct packed {
    decode_data_t instr;
    word_t        srca;
    word_t        srcb;
  } idex_data_t;

  // Occupancy of the register (mirrors out_valid).
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } idex_state_e;

  // Forwarded value wins over the register-file read when enabled.
  function automatic word_t resolve_operand(input fwd_data_t fwd, input word_t rf);
    return fwd.enable ? fwd.data : rf;
  endfunction

endpackage

// File: rtl/idex_reg_if.sv
// Bundle of decode-side, hazard-side and execute-side signals of idex_reg.
// slave: the pipeline register itself. master: whoever drives decode/execute.
interface idex_reg_if;
  import idex_reg_pkg::*;

  logic         in_valid;
  logic         in_ready;
  decode_data_t dataD;
  word_t        rd1;
  word_t        rd2;
  fwd_data_t    fwd_srca;
  fwd_data_t    fwd_srcb;
  logic         ex_memread;
  creg_addr_t   ex_dst;
  logic         mem_regwrite;
  creg_addr_t   mem_dst;
  logic         flush;
  logic         exe_ready;
  logic         out_valid;
  idex_data_t   out_data;
  logic [31:0]  perf_bubble_cnt;
  logic [31:0]  perf_hold_cnt;

  modport slave (
    input  in_valid, dataD, rd1, rd2, fwd_srca, fwd_srcb,
    input  ex_memread, ex_dst, mem_regwrite, mem_dst, flush, exe_ready,
    output in_ready, out_valid, out_data, perf_bubble_cnt, perf_hold_cnt
  );

  modport master (
    output in_valid, dataD, rd1, rd2, fwd_srca, fwd_srcb,
    output ex_memread, ex_dst, mem_regwrite, mem_dst, flush, exe_ready,
    input  in_ready, out_valid, out_data, perf_bubble_cnt, perf_hold_cnt
  );

endinterface

// File: rtl/idex_reg_hazard_detect.sv
// Combinational interlock check: a used, non-zero source that matches a load
// in E or any register writer in M cannot be covered by forwarding.
module idex_reg_hazard_detect
  import idex_reg_pkg::*;
(
  input  creg_addr_t i_ra1,
  input  creg_addr_t i_ra2,
  input  logic       i_use_ra1,
  input  logic       i_use_ra2,
  input  logic       i_ex_memread,
  input  creg_addr_t i_ex_dst,
  input  logic       i_mem_regwrite,
  input  creg_addr_t i_mem_dst,
  output logic       o_hazard
);

  creg_addr_t w_src [2];
  logic [1:0] w_use;
  logic [1:0] w_hit;

  assign w_src[0] = i_ra1;
  assign w_src[1] = i_ra2;
  assign w_use    = {i_use_ra2, i_use_ra1};

  // x0 never creates a dependency, so it is excluded before matching.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_hit[gi] = w_use[gi] && (w_src[gi] != '0) &&
                         ((i_ex_memread   && (i_ex_dst  == w_src[gi])) ||
                          (i_mem_regwrite && (i_mem_dst == w_src[gi])));
    end
  endgenerate

  assign o_hazard = |w_hit;

endmodule

// File: rtl/idex_reg.sv
// Decode-to-execute pipeline register with operand capture, load-use / M-stage
// interlock, execute backpressure and flush. Optional performance counters are
// built only when IDEX_PERF_EN is defined; otherwise the counter ports read 0.
module idex_reg
  import idex_reg_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  idex_reg_if.slave  bus
);

  logic        w_hazard;
  logic        w_advance;
  logic        w_capture;
  word_t       w_srca;
  word_t       w_srcb;
  idex_state_e r_state;
  idex_state_e w_state_next;
  idex_data_t  r_data;

  idex_reg_hazard_detect u_hazard (
    .i_ra1          (bus.dataD.ra1),
    .i_ra2          (bus.dataD.ra2),
    .i_use_ra1      (bus.dataD.ctl.use_ra1),
    .i_use_ra2      (bus.dataD.ctl.use_ra2),
    .i_ex_memread   (bus.ex_memread),
    .i_ex_dst       (bus.ex_dst),
    .i_mem_regwrite (bus.mem_regwrite),
    .i_mem_dst      (bus.mem_dst),
    .o_hazard       (w_hazard)
  );

  // Forwarding is only looked at here; once captured, operands are frozen.
  assign w_srca    = resolve_operand(bus.fwd_srca, bus.rd1);
  assign w_srcb    = resolve_operand(bus.fwd_srcb, bus.rd2);

  assign w_advance = bus.exe_ready || (r_state == ST_EMPTY);
  assign w_capture = w_advance && bus.in_valid && !w_hazard && !bus.flush;
  assign bus.in_ready = w_advance && !w_hazard && !bus.flush;

  // Next occupancy: flush empties, capture fills, advance without capture
  // drains to a bubble, otherwise hold.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_EMPTY;
    end else if (w_capture) begin
      w_state_next = ST_FULL;
    end else if (w_advance) begin
      w_state_next = ST_EMPTY;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload register: loads only on capture, holds through bubbles/flush/stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= '{instr: bus.dataD, srca: w_srca, srcb: w_srcb};
    end
  end

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_data;

`ifdef IDEX_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  // Bubbles caused by an interlock, and cycles held by execute backpressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else if (!bus.flush) begin
      if (w_advance && bus.in_valid && w_hazard) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (!w_advance) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_bubble_cnt = r_bubble_cnt;
  assign bus.perf_hold_cnt   = r_hold_cnt;
`else
  assign bus.perf_bubble_cnt = '0;
  assign bus.perf_hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_idex_reg.sv
// Self-checking bench for idex_reg: directed test-plan steps followed by
// randomized cycles, all checked against a behavioural model of the register.
module tb_idex_reg;
  import idex_reg_pkg::*;

`ifdef IDEX_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   n_cmp  = 0;
  int   n_fail = 0;

  idex_reg_if bus ();

  idex_reg dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  bit          m_valid;
  idex_data_t  m_data;
  int unsigned m_bubble;
  int unsigned m_hold;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    creg_addr_t src [2];
    bit         used [2];
    src[0]  = bus.dataD.ra1;
    src[1]  = bus.dataD.ra2;
    used[0] = bus.dataD.ctl.use_ra1;
    used[1] = bus.dataD.ctl.use_ra2;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && src[i] != 0) begin
        if (bus.ex_memread && bus.ex_dst == src[i]) return 1'b1;
        if (bus.mem_regwrite && bus.mem_dst == src[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_bubble = 0;
    m_hold   = 0;
  endtask

  task automatic check_counters();
    check("perf_bubble_cnt", 128'(bus.perf_bubble_cnt), PERF_EN ? 128'(m_bubble) : 128'd0);
    check("perf_hold_cnt",   128'(bus.perf_hold_cnt),   PERF_EN ? 128'(m_hold)   : 128'd0);
  endtask

  // One clock cycle with the currently driven inputs. Called just after a
  // negedge; returns at the following negedge.
  task automatic step();
    bit hz, adv;
    #1;
    hz  = model_hazard();
    adv = bus.exe_ready || !m_valid;
    check("in_ready", 128'(bus.in_ready), 128'(adv && !hz && !bus.flush));
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (adv && bus.in_valid && !hz) begin
      m_valid     = 1'b1;
      m_data.instr = bus.dataD;
      m_data.srca  = bus.fwd_srca.enable ? bus.fwd_srca.data : bus.rd1;
      m_data.srcb  = bus.fwd_srcb.enable ? bus.fwd_srcb.data : bus.rd2;
    end else if (adv) begin
      if (bus.in_valid && hz) m_bubble++;
      m_valid = 1'b0;
    end else begin
      m_hold++;
    end
    @(posedge clk);
    #1;
    check("out_valid", 128'(bus.out_valid), 128'(m_valid));
    if (m_valid) check("out_data", 128'(bus.out_data), 128'(m_data));
    check_counters();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.in_valid     = 1'b0;
    bus.dataD        = '0;
    bus.rd1          = '0;
    bus.rd2          = '0;
    bus.fwd_srca     = '0;
    bus.fwd_srcb     = '0;
    bus.ex_memread   = 1'b0;
    bus.ex_dst       = '0;
    bus.mem_regwrite = 1'b0;
    bus.mem_dst      = '0;
    bus.flush        = 1'b0;
    bus.exe_ready    = 1'b1;
  endtask

  initial begin
    logic [7:0] ctl_bits;
    clear_inputs();
    bus.exe_ready = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset out_data",  128'(bus.out_data),  128'd0);
    check_counters();
    check("reset in_ready",  128'(bus.in_ready),  128'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Forwarding select
    clear_inputs();
    bus.in_valid = 1'b1;
    bus.dataD.ra1 = 5'd1; bus.dataD.ra2 = 5'd2; bus.dataD.dst = 5'd3;
    bus.dataD.ctl.use_ra1 = 1'b1; bus.dataD.ctl.use_ra2 = 1'b1;
    bus.rd1 = 32'h11; bus.fwd_srca = '{enable: 1'b1, data: 32'hAA};
    bus.rd2 = 32'h22; bus.fwd_srcb = '{enable: 1'b0, data: 32'hDEAD};
    step();
    check("fwd out_valid", 128'(bus.out_valid), 128'd1);
    check("fwd srca", 128'(bus.out_data.srca), 128'h AA);
    check("fwd srcb", 128'(bus.out_data.srcb), 128'h22);

    // Load-use: load in E, then the load in M, then W-forwarded capture
    clear_inputs();
    bus.in_valid = 1'b1;
    bus.dataD.ra1 = 5'd5; bus.dataD.ctl.use_ra1 = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd5;
    #1 check("loaduse in_ready 1", 128'(bus.in_ready), 128'd0);
    step();
    check("loaduse bubble 1", 128'(bus.out_valid), 128'd0);
    bus.ex_memread = 1'b0; bus.mem_regwrite = 1'b1; bus.mem_dst = 5'd5;
    #1 check("loaduse in_ready 2", 128'(bus.in_ready), 128'd0);
    step();
    check("loaduse bubble 2", 128'(bus.out_valid), 128'd0);
    bus.mem_regwrite = 1'b0; bus.fwd_srca = '{enable: 1'b1, data: 32'h5555};
    step();
    check("loaduse srca", 128'(bus.out_data.srca), 128'h5555);
    check("loaduse bubbles", 128'(bus.perf_bubble_cnt), PERF_EN ? 128'd2 : 128'd0);

    // x0 immunity
    clear_inputs();
    bus.in_valid = 1'b1;
    bus.dataD.ctl.use_ra1 = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd0;
    #1 check("x0 in_ready", 128'(bus.in_ready), 128'd1);
    step();

    // Backpressure: capture 0x1234, then stall three cycles
    clear_inputs();
    bus.in_valid = 1'b1; bus.rd1 = 32'h1234;
    step();
    bus.exe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd1 = $urandom; bus.fwd_srca = '{enable: 1'b1, data: $urandom};
      #1 check("hold in_ready", 128'(bus.in_ready), 128'd0);
      step();
      check("hold srca", 128'(bus.out_data.srca), 128'h1234);
    end
    check("hold count", 128'(bus.perf_hold_cnt), PERF_EN ? 128'd3 : 128'd0);

    // Flush together with a hazard and backpressure
    bus.flush = 1'b1;
    bus.dataD.ra1 = 5'd7; bus.dataD.ctl.use_ra1 = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd7;
    #1 check("flush in_ready", 128'(bus.in_ready), 128'd0);
    step();
    check("flush out_valid", 128'(bus.out_valid), 128'd0);

    // Asynchronous reset in the middle of a hold
    clear_inputs();
    bus.in_valid = 1'b1; bus.rd1 = 32'hCAFE; bus.rd2 = 32'hBEEF;
    step();
    bus.exe_ready = 1'b0;
    step();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("async rst out_valid", 128'(bus.out_valid), 128'd0);
    check("async rst out_data",  128'(bus.out_data),  128'd0);
    check_counters();
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.dataD.ra1    = 5'($urandom_range(0, 3));
      bus.dataD.ra2    = 5'($urandom_range(0, 3));
      bus.dataD.dst    = 5'($urandom_range(0, 31));
      ctl_bits         = 8'($urandom);
      bus.dataD.ctl    = ctl_bits;
      bus.rd1          = $urandom;
      bus.rd2          = $urandom;
      bus.fwd_srca     = '{enable: 1'($urandom_range(0, 1)), data: $urandom};
      bus.fwd_srcb     = '{enable: 1'($urandom_range(0, 1)), data: $urandom};
      bus.ex_memread   = ($urandom_range(0, 2) == 0);
      bus.ex_dst       = 5'($urandom_range(0, 3));
      bus.mem_regwrite = ($urandom_range(0, 2) == 0);
      bus.mem_dst      = 5'($urandom_range(0, 3));
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.exe_ready    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
